// File: rtl/pixel_scheduler.sv
// pixel_scheduler
//   Arbitrates two rectangle-drawing requesters and a full-screen clear onto
//   a single pixel-write port of a VGA adapter, one pixel per clock.
//
//   Parameters
//     SCREEN_W      visible columns
//     SCREEN_H      visible rows
//     CLEAR_COLOUR  colour written by a full-screen clear
//
//   Ports
//     clock, reset              system clock, synchronous active-low reset
//     clear_req                 request a full-screen clear (pulse or level)
//     reqN_valid / reqN_ready   rectangle command handshake, N = 0,1
//     reqN_x, reqN_y            rectangle top-left corner
//     reqN_w, reqN_h            width-1 / height-1 (1..16 pixels)
//     reqN_colour, reqN_fill    colour; 1 = filled, 0 = outline only
//     x, y, colour, plot        registered pixel write to the VGA adapter
//     busy                      an operation is in progress
//     done                      one-cycle pulse after the last pixel
module pixel_scheduler #(
    parameter int          SCREEN_W     = 160,
    parameter int          SCREEN_H     = 120,
    parameter logic [2:0]  CLEAR_COLOUR = 3'b000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear_req,

    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_x,
    input  logic [6:0] req0_y,
    input  logic [3:0] req0_w,
    input  logic [3:0] req0_h,
    input  logic [2:0] req0_colour,
    input  logic       req0_fill,

    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_x,
    input  logic [6:0] req1_y,
    input  logic [3:0] req1_w,
    input  logic [3:0] req1_h,
    input  logic [2:0] req1_colour,
    input  logic       req1_fill,

    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, CLEAR, DRAW} state_t;

    localparam logic [8:0] X_LIMIT = 9'(SCREEN_W);
    localparam logic [7:0] Y_LIMIT = 8'(SCREEN_H);
    localparam logic [7:0] X_LAST  = 8'(SCREEN_W - 1);
    localparam logic [6:0] Y_LAST  = 7'(SCREEN_H - 1);

    state_t     state;
    logic       clear_pending;
    logic       last_grant;     // 1 = req1 was granted last, so req0 wins a tie

    // Latched rectangle command
    logic [7:0] base_x;
    logic [6:0] base_y;
    logic [3:0] lat_w, lat_h;
    logic [2:0] lat_colour;
    logic       lat_fill;

    // Offsets of the pixel currently on the outputs
    logic [3:0] col_off, row_off;
    logic [7:0] clr_x;
    logic [6:0] clr_y;

    // A rectangle step is visible when on screen and either filled or on the border.
    function automatic logic step_plot(input logic [8:0] px, input logic [7:0] py,
                                       input logic [3:0] col, input logic [3:0] row,
                                       input logic [3:0] w,   input logic [3:0] h,
                                       input logic       fill);
        logic on_screen, on_border;
        on_screen = (px < X_LIMIT) && (py < Y_LIMIT);
        on_border = (col == 4'd0) || (col == w) || (row == 4'd0) || (row == h);
        return on_screen && (fill || on_border);
    endfunction

    // ------------------------------------------------------------------
    // Arbitration: grants only in a quiet IDLE cycle (no done, no clear)
    // ------------------------------------------------------------------
    logic       can_grant, grant0, grant1;
    logic [7:0] sel_x;
    logic [6:0] sel_y;
    logic [3:0] sel_w, sel_h;
    logic [2:0] sel_colour;
    logic       sel_fill, start_plot;

    assign can_grant  = reset && (state == IDLE) && !done && !clear_req && !clear_pending;
    assign grant0     = can_grant && req0_valid && (!req1_valid || last_grant);
    assign grant1     = can_grant && req1_valid && !grant0;
    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign busy       = (state != IDLE);

    assign sel_x      = grant1 ? req1_x      : req0_x;
    assign sel_y      = grant1 ? req1_y      : req0_y;
    assign sel_w      = grant1 ? req1_w      : req0_w;
    assign sel_h      = grant1 ? req1_h      : req0_h;
    assign sel_colour = grant1 ? req1_colour : req0_colour;
    assign sel_fill   = grant1 ? req1_fill   : req0_fill;
    assign start_plot = step_plot({1'b0, sel_x}, {1'b0, sel_y}, 4'd0, 4'd0,
                                  sel_w, sel_h, sel_fill);

    // ------------------------------------------------------------------
    // Next DRAW step (row-major, column inner)
    // ------------------------------------------------------------------
    logic       last_col, last_row;
    logic [3:0] nxt_col, nxt_row;
    logic [8:0] draw_px;
    logic [7:0] draw_py;
    logic       draw_plot;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        last_col  = (col_off == lat_w);
        last_row  = (row_off == lat_h);
        nxt_col   = col_off + 4'd1;
        nxt_row   = row_off;
        if (last_col) begin
            nxt_col = 4'd0;
            nxt_row = row_off + 4'd1;
        end
        // Computed one bit wider than the outputs so the clip test sees overflow.
        draw_px   = {1'b0, base_x} + {5'b0, nxt_col};
        draw_py   = {1'b0, base_y} + {4'b0, nxt_row};
        draw_plot = step_plot(draw_px, draw_py, nxt_col, nxt_row, lat_w, lat_h, lat_fill);
    end

    // ------------------------------------------------------------------
    // State machine with registered pixel outputs
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side below reads the pre-edge value.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            clear_pending <= 1'b0;
            last_grant    <= 1'b1;
            base_x        <= '0;
            base_y        <= '0;
            lat_w         <= '0;
            lat_h         <= '0;
            lat_colour    <= '0;
            lat_fill      <= 1'b0;
            col_off       <= '0;
            row_off       <= '0;
            clr_x         <= '0;
            clr_y         <= '0;
            x             <= '0;
            y             <= '0;
            colour        <= '0;
            plot          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear_req && state != IDLE)
                clear_pending <= 1'b1;

            case (state)
                IDLE: begin
                    plot <= 1'b0;
                    if (clear_req || clear_pending) begin
                        state         <= CLEAR;
                        clear_pending <= 1'b0;
                        clr_x         <= '0;
                        clr_y         <= '0;
                        x             <= '0;
                        y             <= '0;
                        colour        <= CLEAR_COLOUR;
                        plot          <= 1'b1;
                    end else if (grant0 || grant1) begin
                        state      <= DRAW;
                        last_grant <= grant1;
                        base_x     <= sel_x;
                        base_y     <= sel_y;
                        lat_w      <= sel_w;
                        lat_h      <= sel_h;
                        lat_colour <= sel_colour;
                        lat_fill   <= sel_fill;
                        col_off    <= '0;
                        row_off    <= '0;
                        x          <= sel_x;
                        y          <= sel_y;
                        colour     <= sel_colour;
                        plot       <= start_plot;
                    end
                end

                CLEAR: begin
                    if (clr_x == X_LAST && clr_y == Y_LAST) begin
                        state <= IDLE;
                        plot  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        if (clr_x == X_LAST) begin
                            clr_x <= '0;
                            clr_y <= clr_y + 7'd1;
                            x     <= '0;
                            y     <= clr_y + 7'd1;
                        end else begin
                            clr_x <= clr_x + 8'd1;
                            x     <= clr_x + 8'd1;
                        end
                        plot <= 1'b1;
                    end
                end

                DRAW: begin
                    if (last_col && last_row) begin
                        state <= IDLE;
                        plot  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        col_off <= nxt_col;
                        row_off <= nxt_row;
                        x       <= draw_px[7:0];
                        y       <= draw_py[6:0];
                        colour  <= lat_colour;
                        plot    <= draw_plot;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_scheduler.sv
// Directed testbench for pixel_scheduler: reset state, round-robin grants,
// filled / outline / clipped rectangles, clear collapse and reset mid-clear.
module tb_pixel_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       clear_req = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_x = '0, req1_x = '0;
    logic [6:0] req0_y = '0, req1_y = '0;
    logic [3:0] req0_w = '0, req1_w = '0, req0_h = '0, req1_h = '0;
    logic [2:0] req0_colour = '0, req1_colour = '0;
    logic       req0_fill = 1'b0, req1_fill = 1'b0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done;

    int n_checks = 0;
    int n_errors = 0;

    pixel_scheduler dut (
        .clock(clock), .reset(reset), .clear_req(clear_req),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y),
        .req0_w(req0_w), .req0_h(req0_h), .req0_colour(req0_colour), .req0_fill(req0_fill),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y),
        .req1_w(req1_w), .req1_h(req1_h), .req1_colour(req1_colour), .req1_fill(req1_fill),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
    );

    always #10 clock = ~clock;   // 50 MHz

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Advance to the sampling point of the next cycle (just after the falling edge).
    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic set_cmd(input int port, input int bx, input int by, input int w, input int h,
                           input int col, input bit fill, input bit valid);
        if (port == 0) begin
            req0_x = 8'(bx); req0_y = 7'(by); req0_w = 4'(w); req0_h = 4'(h);
            req0_colour = 3'(col); req0_fill = fill; req0_valid = valid;
        end else begin
            req1_x = 8'(bx); req1_y = 7'(by); req1_w = 4'(w); req1_h = 4'(h);
            req1_colour = 3'(col); req1_fill = fill; req1_valid = valid;
        end
    endtask

    // Handshake one command, then check every step against the rectangle model
    // and the trailing done cycle. clr_a/clr_b: steps at which clear_req pulses.
    task automatic run_rect(input int port, input int bx, input int by, input int w, input int h,
                            input int col, input bit fill, input int clr_a, input int clr_b,
                            input bit raise1, output int plots);
        bit ok = 0;
        int ex = 0, ey = 0;
        plots = 0;
        set_cmd(port, bx, by, w, h, col, fill, 1'b1);
        #1;
        for (int i = 0; i < 50; i++) begin
            if ((port == 0) ? req0_ready : req1_ready) begin
                ok = 1;
                check("hs_single_ready", {31'b0, req0_ready & req1_ready}, 0);
                break;
            end
            step();
        end
        check("hs_granted", {31'b0, ok}, 1);
        if (!ok) return;
        step();
        if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        for (int k = 0; k < (w + 1) * (h + 1); k++) begin
            int c, r;
            bit eplot;
            clear_req = 1'b0;
            if (raise1 && k == 0) req1_valid = 1'b1;
            c = k % (w + 1);
            r = k / (w + 1);
            ex = bx + c;
            ey = by + r;
            eplot = (ex < 160) && (ey < 120) && (fill || c == 0 || c == w || r == 0 || r == h);
            check("px_plot", {31'b0, plot}, {31'b0, eplot});
            check("px_x", {24'b0, x}, ex & 255);
            check("px_y", {25'b0, y}, ey & 127);
            check("px_colour", {29'b0, colour}, col);
            check("px_busy", {31'b0, busy}, 1);
            check("px_no_ready", {30'b0, req0_ready, req1_ready}, 0);
            if (plot) plots++;
            if (k == clr_a || k == clr_b) clear_req = 1'b1;
            step();
        end
        clear_req = 1'b0;
        check("done_pulse", {31'b0, done}, 1);
        check("done_plot", {31'b0, plot}, 0);
        check("done_busy", {31'b0, busy}, 0);
        check("done_no_grant", {30'b0, req0_ready, req1_ready}, 0);
        check("idle_hold_x", {24'b0, x}, ex & 255);
        check("idle_hold_y", {25'b0, y}, ey & 127);
    endtask

    initial begin
        int plots, grants, seq_err, clr_cnt, ex, ey;
        bit seen;

        // ---------------- reset state (valid held high to test gating) --------
        req0_valid = 1'b1;
        repeat (3) step();
        check("rst_x", {24'b0, x}, 0);
        check("rst_y", {25'b0, y}, 0);
        check("rst_colour", {29'b0, colour}, 0);
        check("rst_plot_busy_done", {29'b0, plot, busy, done}, 0);
        check("rst_ready", {30'b0, req0_ready, req1_ready}, 0);

        // ---------------- round robin, both valid, 1-pixel commands ----------
        set_cmd(0, 1, 1, 0, 0, 1, 1'b1, 1'b1);
        set_cmd(1, 2, 2, 0, 0, 2, 1'b0, 1'b1);
        reset = 1'b1;
        #1;
        grants = 0;
        for (int i = 0; i < 40 && grants < 4; i++) begin
            check("rr_not_both", {31'b0, req0_ready & req1_ready}, 0);
            if (req0_ready || req1_ready) begin
                check("rr_order", {31'b0, req1_ready}, grants % 2);
                grants++;
            end
            if (grants < 4) step();
        end
        check("rr_grant_count", grants, 4);
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("rr_w0_plot", {31'b0, plot}, 1);   // w=h=0, fill=0 still plots
        check("rr_w0_xy", {17'b0, x, y}, {17'b0, 8'd2, 7'd2});
        step();
        check("rr_w0_done", {31'b0, done}, 1);
        step();

        // ---------------- filled 4x2 ------------------------------------------
        run_rect(0, 10, 20, 3, 1, 3'b100, 1'b1, -1, -1, 1'b0, plots);
        check("fill_plots", plots, 8);
        step();
        check("done_one_cycle", {31'b0, done}, 0);

        // ---------------- outline 4x4 ------------------------------------------
        run_rect(0, 10, 20, 3, 3, 3'b100, 1'b0, -1, -1, 1'b0, plots);
        check("outline_plots", plots, 12);
        step();

        // ---------------- clipped corner ---------------------------------------
        run_rect(0, 158, 118, 3, 3, 3'b010, 1'b1, -1, -1, 1'b0, plots);
        check("clip_plots", plots, 4);
        step();

        // ---------------- two clear pulses during a draw, req1 waiting --------
        set_cmd(1, 40, 50, 0, 0, 3'b111, 1'b1, 1'b0);
        run_rect(0, 30, 30, 3, 3, 3'b001, 1'b1, 3, 7, 1'b1, plots);
        check("clr_draw_plots", plots, 16);
        clr_cnt = 0; seq_err = 0; ex = 0; ey = 0; seen = 0;
        for (int i = 0; i < 19300; i++) begin
            step();
            if (done) begin seen = 1; break; end
            if (!plot || x != 8'(ex) || y != 7'(ey) || colour != 3'b000) seq_err++;
            clr_cnt++;
            if (ex == 159) begin ex = 0; ey++; end else ex++;
        end
        check("clear_done_seen", {31'b0, seen}, 1);
        check("clear_plot_count", clr_cnt, 19200);
        check("clear_seq_errors", seq_err, 0);
        check("clear_done_no_grant", {31'b0, req1_ready}, 0);
        step();
        check("single_clear_then_req1", {31'b0, req1_ready}, 1);
        run_rect(1, 40, 50, 0, 0, 3'b111, 1'b1, -1, -1, 1'b0, plots);
        check("req1_plots", plots, 1);
        step();

        // ---------------- reset mid-clear at pixel 500 -------------------------
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        clr_cnt = 0;
        for (int i = 0; i < 600 && clr_cnt < 500; i++) begin
            if (plot) clr_cnt++;
            if (clr_cnt < 500) step();
        end
        check("mid_clear_count", clr_cnt, 500);
        check("mid_clear_busy", {31'b0, busy}, 1);
        reset = 1'b0;
        step();
        check("abort_x", {24'b0, x}, 0);
        check("abort_y", {25'b0, y}, 0);
        check("abort_colour", {29'b0, colour}, 0);
        check("abort_plot_busy_done", {29'b0, plot, busy, done}, 0);
        check("abort_ready", {30'b0, req0_ready, req1_ready}, 0);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done || plot || busy) seen = 1;
        end
        check("abort_quiet_after", {31'b0, seen}, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
